// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package clk_div_pkg;

  // Divider operating state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SHOT = 2'd2
  } state_t;

  // Divisor used out of reset: 100 MHz core clock down to a 1 kHz tick
  localparam int unsigned DIV_RST_DEFAULT = 32'd100000;

endpackage

// File: rtl/clk_div_cnt.sv
// Wrapping period counter: counts 0..n-1 while run is high, flags the terminal count.
// Latency: term is combinational on the current count; cnt updates on the next edge.
// Backpressure: none; clear has priority over run, run=0 holds the count.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] last;

  // n is always at least 1, so n-1 cannot underflow
  assign last = n - CNT_W'(1);
  assign term = run && (cnt == last);

  // Advance and wrap the count; it is never allowed past n-1
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= term ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Programmable clock divider: continuous or one-shot tick plus optional ~50% duty waveform (CLK_DIV_DUTY_EN).
// Latency: first tick_o N cycles after leaving IDLE; tick_o/clk_div_o registered one cycle after the count.
// Backpressure: none; divisor writes are shadowed and take effect only at a period boundary or in IDLE.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int unsigned DIV_RST = DIV_RST_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             div_wr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             clk_div_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] div_o
);

  localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(DIV_RST);

  state_t           state;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] shadow_q;
  logic             pend_q;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             run_cyc;
  logic             tick_q;
  logic             busy_q;

  // Divisors 0 and 1 both mean "tick every cycle"
  assign n_eff = (div_q > CNT_W'(1)) ? div_q : CNT_W'(1);

  // A cycle counts when one-shot is active or continuous mode stays enabled;
  // the cycle in which en_i drops while running is not counted
  assign run_cyc = (state == ST_SHOT) || ((state == ST_RUN) && en_i);

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst   (rst),
    .clear (!run_cyc),
    .run   (run_cyc),
    .n     (n_eff),
    .cnt   (cnt),
    .term  (term)
  );

  // Mode FSM with registered tick and busy outputs
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      tick_q <= term;
      case (state)
        ST_IDLE: begin
          if (en_i) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end else if (start_i) begin
            state  <= ST_SHOT;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_SHOT: begin
          // en_i promotes the shot to continuous mode without restarting the count
          if (en_i) begin
            state <= ST_RUN;
          end else if (term) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Shadowed divisor: applied immediately in IDLE, otherwise only at a terminal cycle
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_RST_W;
      shadow_q <= DIV_RST_W;
      pend_q   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (div_wr_i) begin
        div_q    <= div_i;
        shadow_q <= div_i;
        pend_q   <= 1'b0;
      end else if (pend_q) begin
        div_q  <= shadow_q;
        pend_q <= 1'b0;
      end
    end else begin
      if (div_wr_i) begin
        shadow_q <= div_i;
        if (term) begin
          div_q  <= div_i;
          pend_q <= 1'b0;
        end else begin
          pend_q <= 1'b1;
        end
      end else if (term && pend_q) begin
        div_q  <= shadow_q;
        pend_q <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W-1:0] half;
  logic             clk_div_q;

  // ceil(N/2) without forming N+1, so the full CNT_W range is safe
  assign half = (n_eff >> 1) + {{(CNT_W-1){1'b0}}, n_eff[0]};

  // High for the first ceil(N/2) counts of each period, low for N=1
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      clk_div_q <= 1'b0;
    end else begin
      clk_div_q <= run_cyc && (n_eff != CNT_W'(1)) && (cnt < half);
    end
  end

  assign clk_div_o = clk_div_q;
`else
  assign clk_div_o = 1'b0;
`endif

  assign tick_o = tick_q;
  assign busy_o = busy_q;
  assign div_o  = div_q;

  // Divisor updates only at period boundaries keep the count inside the period
  a_cnt_in_range: assert property (@(posedge clk_i) disable iff (rst) cnt < n_eff);

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed scoreboard bench for clk_div_gen: expected per-cycle snapshots queued, monitor compares.
// Latency: snapshots are tagged with the absolute clock cycle they belong to.
// Backpressure: none; stimulus runs ahead, monitor pops in cycle order on the falling edge.
module tb_clk_div_gen;

`ifdef CLK_DIV_DUTY_EN
  localparam logic DUTY = 1'b1;
`else
  localparam logic DUTY = 1'b0;
`endif

  logic        clk_i;
  logic        rst;
  logic        en_i;
  logic        start_i;
  logic        div_wr_i;
  logic [31:0] div_i;
  logic        tick_o;
  logic        clk_div_o;
  logic        busy_o;
  logic [31:0] div_o;

  clk_div_gen #(
    .CNT_W   (32),
    .DIV_RST (100000)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .en_i      (en_i),
    .start_i   (start_i),
    .div_wr_i  (div_wr_i),
    .div_i     (div_i),
    .tick_o    (tick_o),
    .clk_div_o (clk_div_o),
    .busy_o    (busy_o),
    .div_o     (div_o)
  );

  typedef struct {
    int          cyc;
    logic        tick;
    logic        cdiv;
    logic        busy;
    logic [31:0] div;
    int          kind;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   done   = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc = cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0:       return "reset";
      1:       return "idle_wr";
      2:       return "cont_n4";
      3:       return "odd_n5";
      4:       return "rewrite";
      5:       return "oneshot";
      6:       return "edge_div";
      7:       return "reset_mid";
      default: return "misc";
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic snap(input int c, input logic t, input logic cd, input logic b,
                      input logic [31:0] d, input int k);
    exp_t e;
    e.cyc  = c;
    e.tick = t;
    e.cdiv = cd;
    e.busy = b;
    e.div  = d;
    e.kind = k;
    sb.push_back(e);
  endtask

  // Patterns are written MSB first: bit n-1 is the first cycle of the window
  task automatic push_period(input int c0, input int n, input logic [15:0] tp,
                             input logic [15:0] cp, input logic [31:0] d, input int k);
    for (int i = 0; i < n; i++) begin
      snap(c0 + i, tp[n-1-i], DUTY & cp[n-1-i], 1'b1, d, k);
    end
  endtask

  // Divisor write in IDLE must show on div_o right after the edge
  task automatic wr_div(input logic [31:0] v);
    div_wr_i = 1'b1;
    div_i    = v;
    step();
    div_wr_i = 1'b0;
    snap(cyc, 1'b0, 1'b0, 1'b0, v, 1);
  endtask

  // Monitor: compare every queued snapshot at the falling edge of its cycle
  always @(negedge clk_i) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_chk = n_chk + 1;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s snapshot cyc=%0d sampled at cyc=%0d, required same cycle",
                 kname(mon_e.kind), mon_e.cyc, cyc);
      end else if (tick_o === mon_e.tick && clk_div_o === mon_e.cdiv &&
                   busy_o === mon_e.busy && div_o === mon_e.div) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s cyc=%0d got tick=%b clk_div=%b busy=%b div=%0d required tick=%b clk_div=%b busy=%b div=%0d",
                 kname(mon_e.kind), cyc, tick_o, clk_div_o, busy_o, div_o,
                 mon_e.tick, mon_e.cdiv, mon_e.busy, mon_e.div);
      end
    end
    if (done) begin
      n_chk = n_chk + 1;
      if (sb.size() == 0) n_pass = n_pass + 1;
      else $display("FAIL sb_drain got %0d pending snapshots required 0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    int e;
    rst      = 1'b1;
    en_i     = 1'b0;
    start_i  = 1'b0;
    div_wr_i = 1'b0;
    div_i    = '0;

    // Reset state
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd100000, 0);
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd100000, 0);
    rst = 1'b0;
    step();

    // Continuous N=4: tick every 4th cycle, duty 1100
    wr_div(32'd4);
    en_i = 1'b1;
    step();
    e = cyc;
    snap(e, 1'b0, 1'b0, 1'b1, 32'd4, 2);
    for (int p = 0; p < 3; p++) push_period(e + 1 + 4*p, 4, 16'b0001, 16'b1100, 32'd4, 2);
    steps(12);
    en_i = 1'b0;
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd4, 2);

    // Odd N=5: duty 11100
    wr_div(32'd5);
    en_i = 1'b1;
    step();
    e = cyc;
    snap(e, 1'b0, 1'b0, 1'b1, 32'd5, 3);
    for (int p = 0; p < 2; p++) push_period(e + 1 + 5*p, 5, 16'b00001, 16'b11100, 32'd5, 3);
    steps(10);
    en_i = 1'b0;
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd5, 3);

    // N=10 rewritten to 3 at cnt=2, then 2 written exactly on a terminal cycle
    wr_div(32'd10);
    en_i = 1'b1;
    step();
    e = cyc;
    snap(e, 1'b0, 1'b0, 1'b1, 32'd10, 4);
    push_period(e + 1, 9, 16'b000000000, 16'b111110000, 32'd10, 4);
    snap(e + 10, 1'b1, 1'b0, 1'b1, 32'd3, 4);
    push_period(e + 11, 8, 16'b00100100, 16'b11011011, 32'd3, 4);
    snap(e + 19, 1'b1, 1'b0, 1'b1, 32'd2, 4);
    push_period(e + 20, 4, 16'b0101, 16'b1010, 32'd2, 4);
    steps(2);
    div_wr_i = 1'b1;
    div_i    = 32'd3;
    step();
    div_wr_i = 1'b0;
    steps(15);
    div_wr_i = 1'b1;
    div_i    = 32'd2;
    step();
    div_wr_i = 1'b0;
    steps(4);
    en_i = 1'b0;
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd2, 4);

    // One-shot N=6, with a second start pulse mid-shot that must be ignored
    wr_div(32'd6);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    e = cyc;
    snap(e, 1'b0, 1'b0, 1'b1, 32'd6, 5);
    push_period(e + 1, 5, 16'b00000, 16'b11100, 32'd6, 5);
    snap(e + 6, 1'b1, 1'b0, 1'b0, 32'd6, 5);
    snap(e + 7, 1'b0, 1'b0, 1'b0, 32'd6, 5);
    snap(e + 8, 1'b0, 1'b0, 1'b0, 32'd6, 5);
    steps(2);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    steps(6);

    // Divisors 0 and 1: tick every cycle, waveform held low
    for (int d = 0; d < 2; d++) begin
      wr_div(32'(d));
      en_i = 1'b1;
      step();
      e = cyc;
      snap(e, 1'b0, 1'b0, 1'b1, 32'(d), 6);
      push_period(e + 1, 4, 16'b1111, 16'b0000, 32'(d), 6);
      steps(4);
      en_i = 1'b0;
      step();
      snap(cyc, 1'b0, 1'b0, 1'b0, 32'(d), 6);
    end

    // Asynchronous reset in the middle of an N=4 period
    wr_div(32'd4);
    en_i = 1'b1;
    step();
    e = cyc;
    snap(e, 1'b0, 1'b0, 1'b1, 32'd4, 7);
    snap(e + 1, 1'b0, DUTY, 1'b1, 32'd4, 7);
    steps(2);
    rst = 1'b1;
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd100000, 7);
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd100000, 7);
    rst = 1'b0;
    step();
    snap(cyc, 1'b0, 1'b0, 1'b1, 32'd100000, 7);
    en_i = 1'b0;
    step();
    snap(cyc, 1'b0, 1'b0, 1'b0, 32'd100000, 7);

    steps(2);
    done = 1'b1;
  end

endmodule
